branch_redirect_controller: RTL
===============================

# branch_redirect_controller

Sequences the fetch-redirect that follows a taken branch or jump resolved in the execute stage. It samples the jump/branch-enable decision and target address, then drives a valid/ready redirect handshake into the Fetch Unit. While the redirect is pending it flushes the wrong-path IF/ID contents and holds execute. It also traps misaligned targets instead of redirecting, and counts completed redirects for performance monitoring.

## Interface
- XLEN, 32, width of PC/target addresses
- COUNT_WIDTH, 32, width of redirect counter
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- ex_valid  input  1  execute stage holds a valid instruction
- ex_jump_branch_enable  input  1  taken decision from the jump/branch unit (J-type or satisfied B-type)
- ex_target_address  input  XLEN  resolved target address
- pipeline_stall  input  1  global stall (memory wait); blocks capture
- fetch_redirect_ready  input  1  Fetch Unit accepts redirect this cycle
- fetch_redirect_valid  output  1  redirect request to Fetch Unit
- fetch_redirect_address  output  XLEN  new PC; stable while valid
- flush  output  1  kill IF/ID stage contents
- ex_hold  output  1  freeze execute stage
- misaligned_fault  output  1  one-cycle instruction-address-misaligned pulse
- fault_address  output  XLEN  offending target, valid with misaligned_fault
- redirect_count  output  COUNT_WIDTH  completed redirects

## Operation
- States: IDLE, REDIRECT, FAULT. Encoding is free. All outputs are registered or decoded from state and registers only, with no combinational path from inputs to outputs.
- Capture condition, evaluated in IDLE only: ex_valid & ex_jump_branch_enable & !pipeline_stall.
  - Target aligned (ex_target_address[1:0]==2'b00): latch target into fetch_redirect_address and go to REDIRECT.
  - Target misaligned: latch target into fault_address and go to FAULT.
- REDIRECT: fetch_redirect_valid=1, flush=1, ex_hold=1.
  - fetch_redirect_address is held constant.
  - On fetch_redirect_ready=1, return to IDLE and increment redirect_count.
  - Otherwise stay in REDIRECT indefinitely.
- FAULT: lasts exactly one cycle. misaligned_fault=1, flush=1, ex_hold=0, fetch_redirect_valid=0. Always returns to IDLE. redirect_count is unchanged.
- IDLE: fetch_redirect_valid, flush, ex_hold and misaligned_fault are all 0. fetch_redirect_address and fault_address retain their last values.
- ex_valid/ex_jump_branch_enable/pipeline_stall are ignored outside IDLE: the instruction then in execute is wrong-path or held.
- pipeline_stall does not affect REDIRECT. The handshake completes regardless.
- redirect_count wraps from 2^COUNT_WIDTH-1 to 0 with no saturation.

## Timing
- Reset values: state=IDLE, every output 0, including fetch_redirect_address, fault_address and redirect_count.
- Reset asserted mid-REDIRECT or mid-FAULT: at the next edge all outputs are 0 and the state is IDLE. The pending redirect is dropped and the count is cleared.
- Latency: capture at edge N. fetch_redirect_valid, flush and ex_hold go high in cycle N+1.
- With fetch_redirect_ready=1 in cycle N+1, all three drop in cycle N+2 and redirect_count updates in cycle N+2. The minimum redirect occupancy is one cycle.
- Handshake: the transfer occurs on any edge where valid & ready. Valid is never deasserted before the transfer, and the address never changes while valid is high.
- Ready asserted while valid=0 has no effect.
- Back-to-back: IDLE is re-entered for at least one cycle between redirects, so the earliest second capture is at the edge ending the first IDLE cycle.
- FAULT: capture at edge N gives misaligned_fault=1 in cycle N+1 only. Capture is possible again at the end of cycle N+2.

## Test plan
- Reset: hold reset 3 cycles while driving ex_valid=1 and ex_jump_branch_enable=1 → all outputs 0 throughout and one cycle after release. Then capture proceeds normally.
- Simple redirect: capture with target 0x0000_0100 and ready tied 1 → in cycle N+1, valid=1, address=0x100, flush=1 and ex_hold=1. In N+2 all are 0 and redirect_count=1.
- Backpressure plus ignored inputs: ready held 0 for 4 cycles while a new taken branch to 0x200 is presented → valid and address=0x100 stay stable for 5 cycles and 0x200 is never latched. The count increments once.
- Stall gating: ex_valid=1 and ex_jump_branch_enable=1 with pipeline_stall=1 for 3 cycles → no transition. When the stall drops, capture occurs at the next edge.
- Misaligned: target 0x0000_0102 → in cycle N+1, misaligned_fault=1, fault_address=0x102, flush=1, ex_hold=0 and fetch_redirect_valid=0. In N+2 everything is 0 and redirect_count is unchanged.
- Wrap plus mid-operation reset: with COUNT_WIDTH=2, perform 4 redirects → count sequence 1,2,3,0. Then assert reset while in REDIRECT → next cycle all outputs 0 and the state is IDLE.

Source files
------------

// File: rtl/branch_redirect_controller.sv
// branch_redirect_controller: turns a taken branch into a fetch redirect handshake.
// A misaligned target raises a one-cycle fault instead of a redirect.
module branch_redirect_controller #(
  parameter int XLEN = 32,
  parameter int COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ex_valid,
  input  logic                   ex_jump_branch_enable,
  input  logic [XLEN-1:0]        ex_target_address,
  input  logic                   pipeline_stall,
  input  logic                   fetch_redirect_ready,
  output logic                   fetch_redirect_valid,
  output logic [XLEN-1:0]        fetch_redirect_address,
  output logic                   flush,
  output logic                   ex_hold,
  output logic                   misaligned_fault,
  output logic [XLEN-1:0]        fault_address,
  output logic [COUNT_WIDTH-1:0] redirect_count
);
  typedef enum logic [1:0] {IDLE, REDIRECT, FAULT} state_t;
  state_t state_q;
  logic valid_q, flush_q, hold_q, fault_q;
  logic [XLEN-1:0] addr_q, fault_addr_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic capture;
  assign capture = ex_valid & ex_jump_branch_enable & ~pipeline_stall;
  // Outputs are registered alongside the state so no input reaches an output combinationally
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      valid_q      <= 1'b0;
      flush_q      <= 1'b0;
      hold_q       <= 1'b0;
      fault_q      <= 1'b0;
      addr_q       <= '0;
      fault_addr_q <= '0;
      count_q      <= '0;
    end else begin
      case (state_q)
        IDLE:
          if (capture && ex_target_address[1:0] == 2'b00) begin
            state_q <= REDIRECT;
            addr_q  <= ex_target_address;
            valid_q <= 1'b1;
            flush_q <= 1'b1;
            hold_q  <= 1'b1;
          end else if (capture) begin
            state_q      <= FAULT;
            fault_addr_q <= ex_target_address;
            fault_q      <= 1'b1;
            flush_q      <= 1'b1;
          end
        REDIRECT:
          if (fetch_redirect_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            flush_q <= 1'b0;
            hold_q  <= 1'b0;
            count_q <= count_q + COUNT_WIDTH'(1);
          end
        FAULT: begin
          state_q <= IDLE;
          fault_q <= 1'b0;
          flush_q <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          flush_q <= 1'b0;
          hold_q  <= 1'b0;
          fault_q <= 1'b0;
        end
      endcase
    end
  end
  assign fetch_redirect_valid   = valid_q;
  assign fetch_redirect_address = addr_q;
  assign flush                  = flush_q;
  assign ex_hold                = hold_q;
  assign misaligned_fault       = fault_q;
  assign fault_address          = fault_addr_q;
  assign redirect_count         = count_q;
endmodule
